// File: rtl/rotl_pkg.sv
// rtl/rotl_pkg.sv - shared helpers for the pipelined rotate-left unit
package rotl_pkg;

    // Widest data word the generic helpers below can handle.
    localparam int MAX_W = 64;

    function automatic int num_stages(input int n);
        return $clog2(n);
    endfunction

    function automatic int amt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic logic [MAX_W-1:0] rotl(
        input logic [MAX_W-1:0] x,
        input int               k,
        input int               n
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] r;
        int               kk;
        kk   = k % n;
        mask = (n >= MAX_W) ? '1 : ((MAX_W'(1) << n) - MAX_W'(1));
        r    = x & mask;
        if (kk != 0) begin
            r = ((r << kk) | (r >> (n - kk))) & mask;
        end
        return r;
    endfunction

endpackage

// File: rtl/rotl_stage.sv
// rtl/rotl_stage.sv - one registered rotate-left-by-SHIFT stage with valid/ready
module rotl_stage
    import rotl_pkg::*;
#(
    parameter int N     = 8,
    parameter int TAG_W = 4,
    parameter int SHIFT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    prev_valid,
    input  logic [N-1:0]            prev_data,
    input  logic [$clog2(N):0]      prev_amt,
    input  logic [TAG_W-1:0]        prev_tag,
    input  logic                    next_ready,
    output logic                    ready,
    output logic                    valid,
    output logic [N-1:0]            data,
    output logic [$clog2(N):0]      amt,
    output logic [TAG_W-1:0]        tag
);

    localparam int BIT = $clog2(SHIFT);

    logic [N-1:0] rotated;
    logic         unused_amt;

    // The whole amount word is forwarded; this stage only consumes bit BIT.
    assign unused_amt = ^prev_amt;

    assign ready = ~valid | next_ready;

    always_comb begin
        rotated = prev_data;
        if (prev_amt[BIT]) begin
            rotated = N'(rotl(MAX_W'(prev_data), SHIFT, N));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            amt   <= '0;
            tag   <= '0;
        end else if (ready) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data <= rotated;
                amt  <= prev_amt;
                tag  <= prev_tag;
            end
        end
    end

endmodule

// File: rtl/rotl_pipe.sv
// rtl/rotl_pipe.sv - pipelined N-bit rotate-left with valid/ready and sideband tag
module rotl_pipe
    import rotl_pkg::*;
#(
    parameter int N     = 8,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N):0]   in_amt,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N-1:0]         out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int S = num_stages(N);

    if (N < 2 || (N & (N - 1)) != 0 || N > MAX_W) begin : g_bad_n
        $error("rotl_pipe: N must be a power of 2 between 2 and %0d", MAX_W);
    end

    // Index 0 is the input port; index s+1 is the output of stage s.
    logic                 vld [S+1];
    logic [N-1:0]         dat [S+1];
    logic [$clog2(N):0]   amq [S+1];
    logic [TAG_W-1:0]     tgq [S+1];
    logic                 rdy [S+1];
    logic                 unused_tail;

    assign vld[0] = in_valid;
    assign dat[0] = in_data;
    assign amq[0] = in_amt;
    assign tgq[0] = in_tag;
    assign rdy[S] = out_ready;

    for (genvar s = 0; s < S; s++) begin : g_stage
        rotl_stage #(
            .N     (N),
            .TAG_W (TAG_W),
            .SHIFT (1 << s)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .prev_valid (vld[s]),
            .prev_data  (dat[s]),
            .prev_amt   (amq[s]),
            .prev_tag   (tgq[s]),
            .next_ready (rdy[s+1]),
            .ready      (rdy[s]),
            .valid      (vld[s+1]),
            .data       (dat[s+1]),
            .amt        (amq[s+1]),
            .tag        (tgq[s+1])
        );
    end

    assign unused_tail = ^amq[S];

    assign in_ready  = rdy[0];
    assign out_valid = vld[S];
    assign out_data  = dat[S];
    assign out_tag   = tgq[S];

    // A stalled output must not change until the consumer takes it.
    a_hold_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_tag)));

endmodule

// File: tb/tb_rotl_pipe.sv
// tb/tb_rotl_pipe.sv - randomized scoreboard bench for rotl_pipe
module tb_rotl_pipe;

    localparam int N     = 8;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     in_data;
    logic [3:0]       in_amt;
    logic [TAG_W-1:0] in_tag;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_valid;
    logic             out_ready;

    rotl_pipe #(.N(N), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_tag    (in_tag),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          tick_no  = 0;
    int          n_emit   = 0;
    int          last_emit_tick = 0;
    bit          last_acc;
    bit          hold_pending = 1'b0;
    logic [7:0]  hold_data;
    logic [3:0]  hold_tag;
    logic [11:0] exp_q [$];
    logic [11:0] emit_log [$];
    int          emit_t [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Bit i of the input lands at bit (i + amt mod 8) of the result.
    function automatic logic [7:0] model_rotl(input logic [7:0] x, input int amt);
        logic [7:0] r;
        int         k;
        k = amt % 8;
        for (int i = 0; i < 8; i++) r[(i + k) % 8] = x[i];
        return r;
    endfunction

    task automatic tick();
        logic [11:0] e;
        @(negedge clk);
        last_acc = in_valid && in_ready && !reset;
        if (hold_pending && !reset) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(hold_data));
            check("hold_tag", 32'(out_tag), 32'(hold_tag));
        end
        if (out_valid && out_ready && !reset) begin
            n_emit++;
            last_emit_tick = tick_no;
            emit_log.push_back({out_data, out_tag});
            emit_t.push_back(tick_no);
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(e[11:4]));
                check("out_tag", 32'(out_tag), 32'(e[3:0]));
            end
        end
        if (last_acc) exp_q.push_back({model_rotl(in_data, int'(in_amt)), in_tag});
        hold_pending = out_valid && !out_ready && !reset;
        hold_data    = out_data;
        hold_tag     = out_tag;
        @(posedge clk);
        #1;
        tick_no++;
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] a, input logic [3:0] t);
        in_data  = d;
        in_amt   = a;
        in_tag   = t;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    logic [7:0] stream_exp [4];
    logic [7:0] bp_exp [5];

    initial begin
        int acc_tick;
        int emit0;
        int sent;
        int guard;

        stream_exp = '{8'h0F, 8'hF0, 8'h4B, 8'hF0};
        bp_exp     = '{8'h22, 8'h88, 8'h99, 8'h44, 8'hAA};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_tag = '0; out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic latency
        emit_log.delete(); emit_t.delete();
        send(8'h81, 4'd1, 4'd3);
        acc_tick = tick_no - 1;
        emit0 = n_emit;
        for (int i = 0; i < 10 && n_emit == emit0; i++) tick();
        check("lat_emitted", 32'(n_emit - emit0), 32'd1);
        check("lat_cycles", 32'(last_emit_tick - acc_tick), 32'd3);
        if (emit_log.size() > 0) check("lat_value", 32'(emit_log[0]), 32'h033);
        drain();

        // Amount coverage 0..15
        emit_log.delete(); emit_t.delete();
        for (int a = 0; a < 16; a++) send(8'h01, 4'(a), 4'(a));
        drain();
        check("amt_count", 32'(emit_log.size()), 32'd16);
        for (int a = 0; a < 16 && a < emit_log.size(); a++)
            check("amt_value", 32'(emit_log[a]), 32'({8'(1 << (a % 8)), 4'(a)}));

        // Streaming back-to-back
        emit_log.delete(); emit_t.delete();
        send(8'hF0, 4'd4, 4'd1);
        send(8'h0F, 4'd4, 4'd2);
        send(8'hA5, 4'd1, 4'd3);
        send(8'h3C, 4'd2, 4'd4);
        drain();
        check("stream_count", 32'(emit_log.size()), 32'd4);
        if (emit_log.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check("stream_value", 32'(emit_log[i]), 32'({stream_exp[i], 4'(i + 1)}));
            check("stream_consecutive", 32'(emit_t[3] - emit_t[0]), 32'd3);
        end

        // Backpressure
        emit_log.delete(); emit_t.delete();
        out_ready = 1'b0;
        send(8'h11, 4'd1, 4'd1);
        send(8'h22, 4'd2, 4'd2);
        send(8'h33, 4'd3, 4'd3);
        in_data = 8'h44; in_amt = 4'd4; in_tag = 4'd4; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_blocked", 32'(last_acc), 32'd0);
        end
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        send(8'h44, 4'd4, 4'd4);
        send(8'h55, 4'd5, 4'd5);
        drain();
        check("bp_count", 32'(emit_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < emit_log.size(); i++)
            check("bp_value", 32'(emit_log[i]), 32'({bp_exp[i], 4'(i + 1)}));

        // Reset mid-flight
        send(8'hA1, 4'd1, 4'd1);
        send(8'hB2, 4'd2, 4'd2);
        reset = 1'b1; in_valid = 1'b1; in_data = 8'hC3; in_amt = 4'd3; in_tag = 4'd7;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        emit0 = n_emit;
        for (int i = 0; i < 6; i++) tick();
        check("mid_rst_no_stale", 32'(n_emit - emit0), 32'd0);

        // Random scoreboard
        sent = 0;
        guard = 0;
        in_valid = 1'b0;
        while (sent < 10000 && guard < 60000) begin
            if (!in_valid && $urandom_range(3) != 0) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                in_amt   = 4'($urandom);
                in_tag   = 4'($urandom);
            end
            out_ready = ($urandom_range(3) != 0);
            tick();
            guard++;
            if (last_acc) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        check("rand_sent", 32'(sent), 32'd10000);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rotl_pipe.md
Name: rotl_pipe

Overview:
- Pipelined N-bit rotate-left unit with a valid/ready handshake on both sides.
- It is the opposite direction to the team's combinational rotate-right barrel shifter, and is used where rotate-left results must be registered and rate-matched to a downstream consumer.
- It has log2(N) registered stages. Stage i conditionally rotates left by 2^i.
- A sideband tag travels with each item. Items leave in the same order they entered.

Parameters:
- N, 8, data width. Must be a power of 2 and at least 2; elaboration fails otherwise.
- TAG_W, 4, width of the sideband tag carried alongside each item.

Ports:
- clk, input, 1, single clock. Rising edge.
- reset, input, 1, synchronous, active-high reset.
- in_data, input, N, word to rotate.
- in_amt, input, $clog2(N)+1, rotate-left amount.
- in_tag, input, TAG_W, sideband value, passed through unchanged.
- in_valid, input, 1, upstream offers an item.
- in_ready, output, 1, the unit can accept an item this cycle.
- out_data, output, N, rotated word.
- out_tag, output, TAG_W, tag of the item in out_data.
- out_valid, output, 1, out_data and out_tag are valid.
- out_ready, input, 1, downstream accepts the item this cycle.

Behaviour:
- Effective rotation is in_amt mod N. Only the low $clog2(N) bits of in_amt are used; the MSB is ignored. For N=8: amt 8 means rotate 0, amt 13 means rotate 5.
- Rotate left by k is defined as {x[N-1-k:0], x[N-1:N-k]}. For k=0 the word is unchanged.
- Pipeline stages s = 0..S-1, where S = $clog2(N).
  - Each stage holds registers v[s], d[s], a[s] (amount bits not yet applied) and t[s].
  - Stage s loads its predecessor's data, rotated left by 2^s if amount bit s is 1, otherwise unrotated.
  - Stage 0's predecessor is the input port.
- Stage ready: rdy[s] = ~v[s] | rdy[s+1], with rdy[S] = out_ready. in_ready = rdy[0], which is combinational.
- When rdy[s] is high:
  - v[s] loads the predecessor's valid (in_valid for s=0).
  - d, a and t load only when the predecessor's valid is 1; otherwise they hold.
- When rdy[s] is low, all of stage s holds.
- out_valid = v[S-1], out_data = d[S-1], out_tag = t[S-1].
- Latency: an item accepted at edge k (in_valid & in_ready) is presented with out_valid=1 after edge k+S. For N=8 that is 3 cycles.
- Throughput: one item per cycle while out_ready stays high.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data and out_tag stay stable.
  - Bubbles collapse. When full, S items are held and in_ready=0.
- Simultaneous accept and emit in the same cycle is allowed at full rate.
- No item is dropped, duplicated or reordered.
- Reset (synchronous, takes effect at the edge where reset=1):
  - All v[s] are cleared to 0, so out_valid=0.
  - d, a, t and out_data, out_tag are cleared to 0.
  - in_ready reads 1 while reset is asserted and after it, provided out_ready is irrelevant (all stages empty).
- Reset mid-operation: every in-flight item is discarded and nothing is emitted for it. An input offered in a reset cycle is not accepted.
- in_valid may be asserted without waiting for in_ready. Upstream must hold its item stable until it is accepted.

Decomposition:
- Package rotl_pkg:
  - Function rotl(x, k) for reference and assertions.
  - Localparam helper computing S from N.
  - Amount-width constant expression $clog2(N)+1.
- Sub-module rotl_stage:
  - Parameters N, TAG_W, SHIFT (=2^s).
  - Contains one registered stage with the valid/ready logic above.
- The top instantiates S copies of rotl_stage with a generate loop and wires the ready chain.

Test Plan (N=8, TAG_W=4, out_ready=1 unless stated):
- Basic latency: data 8'h81, amt 1, tag 3 -> out 8'h03, tag 3, out_valid high exactly 3 cycles after accept.
- Amount coverage: data 8'h01 with amt 0..15 -> out 8'h01<<(amt mod 8). Amt 5 gives 8'h20, amt 8 gives 8'h01, amt 13 gives 8'h20.
- Streaming: 4 back-to-back items (8'hF0 amt 4, 8'h0F amt 4, 8'hA5 amt 1, 8'h3C amt 2) -> 8'h0F, 8'hF0, 8'h4B, 8'hF0 on 4 consecutive cycles, tags in order.
- Backpressure: out_ready=0 while 5 items are offered -> in_ready low after 3 accepts and out_data held stable. Then out_ready=1 -> all 5 items emerge in order with correct values.
- Reset mid-flight: 2 items in flight, assert reset for 1 cycle -> out_valid=0 and out_data=0 from the next cycle, no stale item emitted, in_ready=1.
- Random scoreboard: 10k random data/amt/tag with random in_valid and out_ready -> each output equals rotl_pkg::rotl(data, amt mod 8), order preserved.
